// File: rtl/swarm_pkg.sv
// Shared types for the tile task-enqueue path: task payload, queue slot,
// epoch, sender TSB entry and tile identifiers.
package swarm;

    localparam int LOG_TQ_SIZE = 3;
    localparam int EPOCH_W     = 8;
    localparam int TASK_W      = 64;
    localparam int TSB_ID_W    = 4;
    localparam int TILE_ID_W   = 4;

    typedef logic [TASK_W-1:0]      task_t;
    typedef logic [LOG_TQ_SIZE-1:0] tq_slot_t;
    typedef logic [EPOCH_W-1:0]     epoch_t;
    typedef logic [TSB_ID_W-1:0]    tsb_entry_id_t;
    typedef logic [TILE_ID_W-1:0]   tile_id_t;

endpackage

// File: rtl/lowbit.sv
// Lowest-set-bit priority encoder: out is the index of the least significant
// set bit of in; valid flags that any bit is set.
module lowbit #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 3
) (
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 valid
);

    logic [IN_WIDTH-1:0] onehot;

    // Each bit wins only if no lower bit is set, so onehot has at most one bit.
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_onehot
        localparam logic [IN_WIDTH-1:0] LOWER_MASK =
            (IN_WIDTH'(1) << gi) - IN_WIDTH'(1);
        assign onehot[gi] = in[gi] & ~(|(in & LOWER_MASK));
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (onehot[i]) begin
                out = out | OUT_WIDTH'(i);
            end
        end
    end

    assign valid = |in;

endmodule

// File: rtl/task_enq_responder.sv
// Tile-side task-enqueue responder: admits remote tasks into free task-queue
// slots, tags them with the slot epoch and returns an ack/nack to the sender.
module task_enq_responder
    import swarm::*;
#(
    parameter int LOG_TQ_SIZE    = swarm::LOG_TQ_SIZE,
    parameter int UNTIED_RESERVE = 2,
    parameter int EPOCH_W        = swarm::EPOCH_W
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          s_valid,
    output logic          s_ready,
    input  task_t         s_data,
    input  logic          s_tied,
    input  tsb_entry_id_t s_tsb_id,
    input  tile_id_t      s_src_tile,

    output logic          tq_wvalid,
    input  logic          tq_wready,
    output task_t         tq_wdata,
    output tq_slot_t      tq_wslot,
    output epoch_t        tq_wepoch,
    output logic          tq_wtied,

    input  logic          free_valid,
    input  tq_slot_t      free_slot,

    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_ack,
    output tsb_entry_id_t resp_tsb_id,
    output epoch_t        resp_epoch,
    output tq_slot_t      resp_tq_slot,
    output tile_id_t      resp_dest_tile,

    output logic [LOG_TQ_SIZE:0] n_used,
    output logic [31:0]   nack_count,
    output logic          err_double_free
);

    localparam int TQ_SIZE = 2 ** LOG_TQ_SIZE;
    localparam int NW      = LOG_TQ_SIZE + 1;
    localparam logic [NW-1:0] LIMIT_TIED   = NW'(TQ_SIZE);
    localparam logic [NW-1:0] LIMIT_UNTIED = NW'(TQ_SIZE - UNTIED_RESERVE);

    logic [TQ_SIZE-1:0] used_q, used_d;
    epoch_t             epoch_q [TQ_SIZE];
    epoch_t             epoch_d [TQ_SIZE];
    logic [NW-1:0]      n_used_q, n_used_d;
    logic [31:0]        nack_count_q, nack_count_d;
    logic               err_double_free_q, err_double_free_d;

    logic               resp_valid_q, resp_valid_d;
    logic               resp_ack_q, resp_ack_d;
    tsb_entry_id_t      resp_tsb_id_q, resp_tsb_id_d;
    epoch_t             resp_epoch_q, resp_epoch_d;
    tq_slot_t           resp_tq_slot_q, resp_tq_slot_d;
    tile_id_t           resp_dest_tile_q, resp_dest_tile_d;

    logic [LOG_TQ_SIZE-1:0] alloc_idx;
    logic                   any_free;
    logic                   out_free;
    logic [NW-1:0]          limit;
    logic                   ok;
    logic                   fire;
    logic                   alloc_fire;
    logic                   valid_free;
    logic                   bad_free;

    lowbit #(
        .IN_WIDTH  (TQ_SIZE),
        .OUT_WIDTH (LOG_TQ_SIZE)
    ) u_free_enc (
        .in    (~used_q),
        .out   (alloc_idx),
        .valid (any_free)
    );

    // Admission sees only registered occupancy, so a slot freed this cycle
    // cannot be handed out until the next one.
    always_comb begin
        out_free   = !resp_valid_q || resp_ready;
        limit      = s_tied ? LIMIT_TIED : LIMIT_UNTIED;
        ok         = any_free && (n_used_q < limit);
        tq_wvalid  = s_valid && out_free && ok;
        s_ready    = out_free && (!ok || tq_wready);
        fire       = s_valid && s_ready;
        alloc_fire = fire && ok;
        valid_free = free_valid && used_q[free_slot];
        bad_free   = free_valid && !used_q[free_slot];
    end

    assign tq_wdata  = s_data;
    assign tq_wslot  = tq_slot_t'(alloc_idx);
    assign tq_wepoch = epoch_q[alloc_idx];
    assign tq_wtied  = s_tied;

    always_comb begin
        used_d = used_q;
        if (valid_free) begin
            used_d[free_slot] = 1'b0;
        end
        if (alloc_fire) begin
            used_d[alloc_idx] = 1'b1;
        end
        n_used_d          = n_used_q + NW'(alloc_fire) - NW'(valid_free);
        err_double_free_d = err_double_free_q || bad_free;
        nack_count_d      = nack_count_q;
        if (fire && !ok && (nack_count_q != 32'hFFFF_FFFF)) begin
            nack_count_d = nack_count_q + 32'd1;
        end
    end

    // Epoch advances on every legal release so stale references to the slot
    // can be told apart from the next occupant.
    for (genvar gi = 0; gi < TQ_SIZE; gi++) begin : g_epoch
        assign epoch_d[gi] = (valid_free && (free_slot == tq_slot_t'(gi)))
                           ? epoch_q[gi] + epoch_t'(1) : epoch_q[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                epoch_q[gi] <= '0;
            end else begin
                epoch_q[gi] <= epoch_d[gi];
            end
        end
    end

    always_comb begin
        resp_valid_d     = resp_valid_q;
        resp_ack_d       = resp_ack_q;
        resp_tsb_id_d    = resp_tsb_id_q;
        resp_epoch_d     = resp_epoch_q;
        resp_tq_slot_d   = resp_tq_slot_q;
        resp_dest_tile_d = resp_dest_tile_q;
        if (fire) begin
            resp_valid_d     = 1'b1;
            resp_ack_d       = ok;
            resp_tsb_id_d    = s_tsb_id;
            resp_dest_tile_d = s_src_tile;
            resp_epoch_d     = ok ? epoch_q[alloc_idx] : '0;
            resp_tq_slot_d   = ok ? tq_slot_t'(alloc_idx) : '0;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q            <= '0;
            n_used_q          <= '0;
            nack_count_q      <= '0;
            err_double_free_q <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_ack_q        <= 1'b0;
            resp_tsb_id_q     <= '0;
            resp_epoch_q      <= '0;
            resp_tq_slot_q    <= '0;
            resp_dest_tile_q  <= '0;
        end else begin
            used_q            <= used_d;
            n_used_q          <= n_used_d;
            nack_count_q      <= nack_count_d;
            err_double_free_q <= err_double_free_d;
            resp_valid_q      <= resp_valid_d;
            resp_ack_q        <= resp_ack_d;
            resp_tsb_id_q     <= resp_tsb_id_d;
            resp_epoch_q      <= resp_epoch_d;
            resp_tq_slot_q    <= resp_tq_slot_d;
            resp_dest_tile_q  <= resp_dest_tile_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_ack        = resp_ack_q;
    assign resp_tsb_id     = resp_tsb_id_q;
    assign resp_epoch      = resp_epoch_q;
    assign resp_tq_slot    = resp_tq_slot_q;
    assign resp_dest_tile  = resp_dest_tile_q;
    assign n_used          = n_used_q;
    assign nack_count      = nack_count_q;
    assign err_double_free = err_double_free_q;

endmodule

// File: tb/tb_task_enq_responder.sv
// Directed bench for task_enq_responder: admission, reserve, epochs,
// backpressure, simultaneous free/alloc and double-free detection.
module tb_task_enq_responder;
    import swarm::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    task_t         s_data;
    logic          s_tied;
    tsb_entry_id_t s_tsb_id;
    tile_id_t      s_src_tile;
    logic          tq_wvalid;
    logic          tq_wready;
    task_t         tq_wdata;
    tq_slot_t      tq_wslot;
    epoch_t        tq_wepoch;
    logic          tq_wtied;
    logic          free_valid;
    tq_slot_t      free_slot;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_ack;
    tsb_entry_id_t resp_tsb_id;
    epoch_t        resp_epoch;
    tq_slot_t      resp_tq_slot;
    tile_id_t      resp_dest_tile;
    logic [3:0]    n_used;
    logic [31:0]   nack_count;
    logic          err_double_free;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task_enq_responder #(
        .LOG_TQ_SIZE    (3),
        .UNTIED_RESERVE (2),
        .EPOCH_W        (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_tied          (s_tied),
        .s_tsb_id        (s_tsb_id),
        .s_src_tile      (s_src_tile),
        .tq_wvalid       (tq_wvalid),
        .tq_wready       (tq_wready),
        .tq_wdata        (tq_wdata),
        .tq_wslot        (tq_wslot),
        .tq_wepoch       (tq_wepoch),
        .tq_wtied        (tq_wtied),
        .free_valid      (free_valid),
        .free_slot       (free_slot),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_ack        (resp_ack),
        .resp_tsb_id     (resp_tsb_id),
        .resp_epoch      (resp_epoch),
        .resp_tq_slot    (resp_tq_slot),
        .resp_dest_tile  (resp_dest_tile),
        .n_used          (n_used),
        .nack_count      (nack_count),
        .err_double_free (err_double_free)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic tied, input logic [3:0] tsb, input logic [3:0] src);
        s_valid    = 1'b1;
        s_tied     = tied;
        s_tsb_id   = tsb;
        s_src_tile = src;
        s_data     = {32'hC0DE_0000, 28'h0, tsb};
    endtask

    task automatic cycle_req(input logic tied, input logic [3:0] tsb, input logic [3:0] src);
        drive_req(tied, tsb, src);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic cycle_free(input logic [2:0] slot);
        free_valid = 1'b1;
        free_slot  = slot;
        tick();
        free_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (resp_valid !== 1'b0 || n_used !== 4'd0 || nack_count !== 32'd0 || err_double_free !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: resp_valid=%b n_used=%0d nack=%0d err=%b, required 0 0 0 0",
                     resp_valid, n_used, nack_count, err_double_free);
        end
        total++;
        if (s_ready !== 1'b1 || tq_wvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: s_ready=%b tq_wvalid=%b, required 1 0", s_ready, tq_wvalid);
        end
        $display("reset: n_used=%0d resp_valid=%b", n_used, resp_valid);
    endtask

    task automatic test_first_enqueue();
        drive_req(1'b1, 4'd5, 4'd2);
        #1;
        total++;
        if (tq_wvalid !== 1'b1 || tq_wslot !== 3'd0 || tq_wepoch !== 8'd0 || tq_wtied !== 1'b1
            || tq_wdata !== s_data) begin
            bad++;
            $display("FAIL first_tq_write: wvalid=%b slot=%0d epoch=%0d tied=%b, required 1 0 0 1",
                     tq_wvalid, tq_wslot, tq_wepoch, tq_wtied);
        end
        tick();
        s_valid = 1'b0;
        total++;
        if (resp_valid !== 1'b1 || resp_ack !== 1'b1 || resp_tq_slot !== 3'd0 || resp_epoch !== 8'd0
            || resp_tsb_id !== 4'd5 || resp_dest_tile !== 4'd2 || n_used !== 4'd1) begin
            bad++;
            $display("FAIL first_resp: v=%b ack=%b slot=%0d ep=%0d tsb=%0d tile=%0d n=%0d, required 1 1 0 0 5 2 1",
                     resp_valid, resp_ack, resp_tq_slot, resp_epoch, resp_tsb_id, resp_dest_tile, n_used);
        end
        $display("first: ack=%b slot=%0d tsb=%0d", resp_ack, resp_tq_slot, resp_tsb_id);
    endtask

    task automatic test_capacity();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle_req(1'b0, 4'(i), 4'd1);
            total++;
            if (resp_valid !== 1'b1 || resp_ack !== 1'b1 || resp_tq_slot !== 3'(i)) begin
                bad++;
                $display("FAIL untied_ack[%0d]: v=%b ack=%b slot=%0d, required 1 1 %0d",
                         i, resp_valid, resp_ack, resp_tq_slot, i);
            end
            $display("untied %0d: ack=%b slot=%0d", i, resp_ack, resp_tq_slot);
        end
        drive_req(1'b0, 4'd6, 4'd1);
        #1;
        total++;
        if (tq_wvalid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL untied_reserve_comb: wvalid=%b s_ready=%b, required 0 1", tq_wvalid, s_ready);
        end
        tick();
        s_valid = 1'b0;
        total++;
        if (resp_ack !== 1'b0 || resp_tq_slot !== 3'd0 || resp_epoch !== 8'd0 || resp_tsb_id !== 4'd6
            || nack_count !== 32'd1 || n_used !== 4'd6) begin
            bad++;
            $display("FAIL untied_nack: ack=%b slot=%0d ep=%0d tsb=%0d nack=%0d n=%0d, required 0 0 0 6 1 6",
                     resp_ack, resp_tq_slot, resp_epoch, resp_tsb_id, nack_count, n_used);
        end
        $display("untied 7th: ack=%b nack_count=%0d", resp_ack, nack_count);
        for (int i = 0; i < 2; i++) begin
            cycle_req(1'b1, 4'(7 + i), 4'd3);
            total++;
            if (resp_ack !== 1'b1 || resp_tq_slot !== 3'(6 + i)) begin
                bad++;
                $display("FAIL tied_ack[%0d]: ack=%b slot=%0d, required 1 %0d", i, resp_ack, resp_tq_slot, 6 + i);
            end
            $display("tied %0d: ack=%b slot=%0d", i, resp_ack, resp_tq_slot);
        end
        cycle_req(1'b1, 4'd9, 4'd3);
        total++;
        if (resp_ack !== 1'b0 || nack_count !== 32'd2 || n_used !== 4'd8) begin
            bad++;
            $display("FAIL tied_full_nack: ack=%b nack=%0d n=%0d, required 0 2 8", resp_ack, nack_count, n_used);
        end
        $display("tied 3rd: ack=%b nack_count=%0d n_used=%0d", resp_ack, nack_count, n_used);
    endtask

    task automatic test_epoch_wrap();
        cycle_free(3'd3);
        cycle_req(1'b1, 4'd1, 4'd4);
        total++;
        if (resp_ack !== 1'b1 || resp_tq_slot !== 3'd3 || resp_epoch !== 8'd1) begin
            bad++;
            $display("FAIL realloc_epoch: ack=%b slot=%0d ep=%0d, required 1 3 1", resp_ack, resp_tq_slot, resp_epoch);
        end
        $display("realloc: slot=%0d epoch=%0d", resp_tq_slot, resp_epoch);
        for (int k = 2; k <= 256; k++) begin
            cycle_free(3'd3);
            cycle_req(1'b1, 4'd1, 4'd4);
            total++;
            if (resp_ack !== 1'b1 || resp_tq_slot !== 3'd3 || resp_epoch !== 8'(k)) begin
                bad++;
                $display("FAIL epoch_iter[%0d]: ack=%b slot=%0d ep=%0d, required 1 3 %0d",
                         k, resp_ack, resp_tq_slot, resp_epoch, k % 256);
            end
        end
        $display("wrap: slot=%0d epoch=%0d", resp_tq_slot, resp_epoch);
    endtask

    task automatic test_backpressure();
        do_reset();
        resp_ready = 1'b0;
        cycle_req(1'b1, 4'd7, 4'd1);
        drive_req(1'b1, 4'd8, 4'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (s_ready !== 1'b0 || tq_wvalid !== 1'b0 || resp_valid !== 1'b1 || resp_ack !== 1'b1
                || resp_tsb_id !== 4'd7 || resp_tq_slot !== 3'd0 || resp_dest_tile !== 4'd1) begin
                bad++;
                $display("FAIL resp_stall[%0d]: s_ready=%b wv=%b v=%b ack=%b tsb=%0d slot=%0d, required 0 0 1 1 7 0",
                         c, s_ready, tq_wvalid, resp_valid, resp_ack, resp_tsb_id, resp_tq_slot);
            end
            tick();
        end
        $display("stall: resp tsb=%0d held, n_used=%0d", resp_tsb_id, n_used);
        resp_ready = 1'b1;
        #1;
        tick();
        s_valid = 1'b0;
        total++;
        if (resp_valid !== 1'b1 || resp_tsb_id !== 4'd8 || resp_tq_slot !== 3'd1 || n_used !== 4'd2) begin
            bad++;
            $display("FAIL stall_release: v=%b tsb=%0d slot=%0d n=%0d, required 1 8 1 2",
                     resp_valid, resp_tsb_id, resp_tq_slot, n_used);
        end
        tq_wready = 1'b0;
        drive_req(1'b1, 4'd9, 4'd1);
        #1;
        total++;
        if (tq_wvalid !== 1'b1 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL tq_stall_comb: wvalid=%b s_ready=%b, required 1 0", tq_wvalid, s_ready);
        end
        tick();
        s_valid   = 1'b0;
        tq_wready = 1'b1;
        total++;
        if (resp_valid !== 1'b0 || n_used !== 4'd2) begin
            bad++;
            $display("FAIL tq_stall_noresp: v=%b n=%0d, required 0 2", resp_valid, n_used);
        end
        $display("tq stall: resp_valid=%b n_used=%0d", resp_valid, n_used);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 4'(10 + i), 4'd6);
            tick();
            total++;
            if (resp_valid !== 1'b1 || resp_ack !== 1'b1 || resp_tsb_id !== 4'(10 + i)
                || resp_tq_slot !== 3'(2 + i)) begin
                bad++;
                $display("FAIL b2b[%0d]: v=%b ack=%b tsb=%0d slot=%0d, required 1 1 %0d %0d",
                         i, resp_valid, resp_ack, resp_tsb_id, resp_tq_slot, 10 + i, 2 + i);
            end
            $display("b2b %0d: tsb=%0d slot=%0d", i, resp_tsb_id, resp_tq_slot);
        end
        s_valid = 1'b0;
        tick();
        total++;
        if (n_used !== 4'd5 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count: n=%0d v=%b, required 5 0", n_used, resp_valid);
        end
    endtask

    task automatic test_simultaneous_free();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle_req(1'b1, 4'(i), 4'd2);
        end
        free_valid = 1'b1;
        free_slot  = 3'd2;
        drive_req(1'b1, 4'd12, 4'd5);
        #1;
        total++;
        if (tq_wvalid !== 1'b0 || n_used !== 4'd8) begin
            bad++;
            $display("FAIL simul_comb: wvalid=%b n=%0d, required 0 8", tq_wvalid, n_used);
        end
        tick();
        free_valid = 1'b0;
        s_valid    = 1'b0;
        total++;
        if (resp_ack !== 1'b0 || resp_tsb_id !== 4'd12 || n_used !== 4'd7) begin
            bad++;
            $display("FAIL simul_nack: ack=%b tsb=%0d n=%0d, required 0 12 7", resp_ack, resp_tsb_id, n_used);
        end
        cycle_req(1'b1, 4'd13, 4'd5);
        total++;
        if (resp_ack !== 1'b1 || resp_tq_slot !== 3'd2 || resp_epoch !== 8'd1 || n_used !== 4'd8) begin
            bad++;
            $display("FAIL simul_next_ack: ack=%b slot=%0d ep=%0d n=%0d, required 1 2 1 8",
                     resp_ack, resp_tq_slot, resp_epoch, n_used);
        end
        $display("simul: next slot=%0d epoch=%0d", resp_tq_slot, resp_epoch);
    endtask

    task automatic test_double_free();
        cycle_free(3'd4);
        cycle_free(3'd4);
        total++;
        if (err_double_free !== 1'b1 || n_used !== 4'd7) begin
            bad++;
            $display("FAIL double_free: err=%b n=%0d, required 1 7", err_double_free, n_used);
        end
        total++;
        if (tq_wslot !== 3'd4 || tq_wepoch !== 8'd1) begin
            bad++;
            $display("FAIL double_free_epoch: slot=%0d ep=%0d, required 4 1", tq_wslot, tq_wepoch);
        end
        for (int c = 0; c < 3; c++) tick();
        total++;
        if (err_double_free !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b, required 1", err_double_free);
        end
        $display("double free: err=%b n_used=%0d", err_double_free, n_used);
        do_reset();
        total++;
        if (err_double_free !== 1'b0 || n_used !== 4'd0) begin
            bad++;
            $display("FAIL err_reset: err=%b n=%0d, required 0 0", err_double_free, n_used);
        end
    endtask

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_tied     = 1'b0;
        s_tsb_id   = '0;
        s_src_tile = '0;
        tq_wready  = 1'b1;
        free_valid = 1'b0;
        free_slot  = '0;
        resp_ready = 1'b1;
        test_reset();
        test_first_enqueue();
        test_capacity();
        test_epoch_wrap();
        test_backpressure();
        test_back_to_back();
        test_simultaneous_free();
        test_double_free();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task_enq_responder.md
Name: task_enq_responder

Overview:
- Tile-side end of the task-enqueue protocol. Accepts remote task enqueue requests addressed to this tile.
- Allocates a task-queue slot and per-slot epoch for each accepted task, and forwards the task to the tile task queue.
- Returns an ack, or a nack when there is no capacity, tagged with the sender's TSB entry id so the sender can free or retry the entry.
- Tracks slot occupancy. Slots are released by the task queue on dequeue, commit or abort.

Parameters:
- LOG_TQ_SIZE, 3, log2 of task-queue slots owned by this block (TQ_SIZE = 2**LOG_TQ_SIZE).
- UNTIED_RESERVE, 2, slots usable only by tied tasks (0 .. TQ_SIZE-1).
- EPOCH_W, 8, epoch width; must match epoch_t.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous and active-high.
- s_valid  in  1  enqueue request valid.
- s_ready  out  1  request consumed when s_valid & s_ready.
- s_data  in  task_t  task payload.
- s_tied  in  1  task is tied to its parent.
- s_tsb_id  in  tsb_entry_id_t  sender TSB entry.
- s_src_tile  in  tile_id_t  sending tile.
- tq_wvalid  out  1  write to task queue.
- tq_wready  in  1  task queue accepts the write.
- tq_wdata  out  task_t  equals s_data.
- tq_wslot  out  tq_slot_t  allocated slot.
- tq_wepoch  out  epoch_t  epoch of the allocated slot.
- tq_wtied  out  1  equals s_tied.
- free_valid  in  1  release a slot.
- free_slot  in  tq_slot_t  slot to release.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed.
- resp_ack  out  1  1 = accepted, 0 = nack/retry.
- resp_tsb_id  out  tsb_entry_id_t  echo of s_tsb_id.
- resp_epoch  out  epoch_t  slot epoch (0 on nack).
- resp_tq_slot  out  tq_slot_t  slot (0 on nack).
- resp_dest_tile  out  tile_id_t  echo of s_src_tile.
- n_used  out  LOG_TQ_SIZE+1  occupied slot count.
- nack_count  out  32  saturating nack counter.
- err_double_free  out  1  sticky: freed a slot that was not in use.

Behaviour:
- State:
  - used[TQ_SIZE] bitmap.
  - epoch[TQ_SIZE] array.
  - n_used counter.
  - One registered response stage.
- Reset (rst=1 at clk edge): used=0, all epochs=0, n_used=0, resp_valid=0, resp_* fields=0, nack_count=0, err_double_free=0. A pending response is dropped; the sender's TSB is reset together.
- Combinational admit logic:
  - out_free = !resp_valid | resp_ready.
  - limit = s_tied ? TQ_SIZE : TQ_SIZE-UNTIED_RESERVE.
  - ok = (used != all-ones) & (n_used < limit).
  - alloc = lowest index with used==0, from the registered bitmap.
  - tq_wvalid = s_valid & out_free & ok.
  - s_ready = out_free & (!ok | tq_wready).
  - tq_w* fields are driven from s_* and alloc every cycle.
- On fire (s_valid & s_ready), with 1-cycle latency to resp_valid:
  - ok=1: used[alloc]<=1; resp_ack=1; resp_tq_slot=alloc; resp_epoch=epoch[alloc].
  - ok=0: nothing is written to the queue; resp_ack=0; slot and epoch fields are 0; nack_count increments, saturating at 2^32-1.
  - resp_tsb_id and resp_dest_tile are always echoed.
- Response stage:
  - resp_valid holds, with all fields stable, until resp_ready.
  - Back-to-back fire is allowed when resp_ready=1, giving full throughput.
- Free:
  - On free_valid with used[free_slot]=1: used<=0 and epoch[free_slot]<=epoch+1, wrapping mod 2^EPOCH_W.
  - On free_valid with used[free_slot]=0: no state change and err_double_free<=1. It stays set until reset.
- Simultaneous alloc and free:
  - They always target different slots, so both apply.
  - n_used <= n_used + alloc_fire - valid_free; the net is unchanged when both occur.
  - A slot freed in cycle N becomes allocatable in cycle N+1, never the same cycle.
- Tied/untied reserve: untied tasks nack once n_used >= TQ_SIZE-UNTIED_RESERVE; tied tasks may use every slot.
- Requests are never reordered or dropped: every fired request yields exactly one response.

Decomposition:
- Shared package swarm: task_t, tq_slot_t, epoch_t, tsb_entry_id_t, tile_id_t, LOG_TQ_SIZE default.
- Free-slot selection reuses the existing lowbit priority encoder, in=~used, OUT_WIDTH=LOG_TQ_SIZE. No other sub-module.

Test Plan:
- Reset, then a tied request with tsb_id=5 from tile 2 -> same cycle tq_wvalid=1, tq_wslot=0; next cycle resp_ack=1, slot 0, epoch 0, resp_tsb_id=5, resp_dest_tile=2; n_used=1.
- Capacity (TQ_SIZE=8, RESERVE=2):
  - 6 untied requests -> acks in slots 0..5.
  - 7th untied -> nack, nack_count=1.
  - 2 tied -> acks in slots 6, 7.
  - 3rd tied -> nack, nack_count=2.
- Free slot 3, then a request -> ack slot 3 with epoch 1. Repeat the free/alloc cycle on slot 3 256 times -> epoch wraps to 0.
- Backpressure:
  - resp_ready=0 with resp_valid=1 -> s_ready=0; response fields stable for 5 cycles.
  - tq_wready=0 with ok=1 -> s_ready=0 and no response generated.
- Full queue, free_valid for slot 2 in the same cycle as a tied request -> nack. A request in the next cycle -> ack slot 2, epoch 1.
- free_valid on an unused slot 4 -> err_double_free=1; n_used and epoch[4] unchanged; err_double_free cleared only by rst.
